// File: rtl/triangle_arbiter_if.sv
// -----------------------------------------------------------------------------
// triangle_arbiter_if
//   Bundles the per-requester beat handshake, the FIFO-facing beat outputs and
//   the credit/grant status of triangle_arbiter.
//
//   slave  : arbiter view (requests and pop in, ready/beats/status out)
//   master : producer/FIFO view (the mirror image)
//
//   req_valid_in / req_ready_out     per-requester beat handshake
//   req_vertex_in [NUM_REQ][4][32]   x,y,z,w float32, sampled on vertex beats
//   req_color_in  [NUM_REQ][12]      RGB444, sampled on the color beat
//   vertex_valid_out / vertex_out    registered vertex beat to the FIFO
//   color_valid_out  / color_out     registered color beat to the FIFO
//   pop_in                           FIFO dequeued one triangle (returns a credit)
//   grant_out                        current or last granted requester
//   credits_out                      free FIFO triangle slots
// -----------------------------------------------------------------------------
interface triangle_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int CREDITS = 4
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(CREDITS + 1);

    logic [NUM_REQ-1:0]            req_valid_in;
    logic [NUM_REQ-1:0][3:0][31:0] req_vertex_in;
    logic [NUM_REQ-1:0][11:0]      req_color_in;
    logic [NUM_REQ-1:0]            req_ready_out;
    logic                          vertex_valid_out;
    logic [3:0][31:0]              vertex_out;
    logic                          color_valid_out;
    logic [11:0]                   color_out;
    logic                          pop_in;
    logic [GW-1:0]                 grant_out;
    logic [CW-1:0]                 credits_out;

    modport slave (
        input  req_valid_in, req_vertex_in, req_color_in, pop_in,
        output req_ready_out, vertex_valid_out, vertex_out,
               color_valid_out, color_out, grant_out, credits_out
    );

    modport master (
        output req_valid_in, req_vertex_in, req_color_in, pop_in,
        input  req_ready_out, vertex_valid_out, vertex_out,
               color_valid_out, color_out, grant_out, credits_out
    );
endinterface

// File: rtl/triangle_arbiter.sv
// -----------------------------------------------------------------------------
// triangle_arbiter
//   Arbitrates NUM_REQ triangle producers onto one triangle FIFO. A grant is
//   held for a whole triangle (3 vertex beats, then 1 color beat) so beats of
//   different requesters never interleave. A credit is reserved at grant time
//   and returned by pop_in, so the FIFO (no input backpressure) cannot overflow.
//
//   Ports:
//     clk_in    system clock
//     rst_n_in  asynchronous active-low reset (FIFO shares this reset domain)
//     bus       triangle_arbiter_if.slave (requests, FIFO beats, pop, status)
//
//   Build option:
//     TRI_ARB_ROUND_ROBIN_EN  defined   -> round-robin selection from a pointer
//                             undefined -> fixed priority, lowest index wins
// -----------------------------------------------------------------------------
module triangle_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int CREDITS = 4
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    triangle_arbiter_if.slave bus
);
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CREDITS_FULL = CW'(CREDITS);

    typedef enum logic [1:0] {IDLE, VERTEX, COLOR} state_e;

    state_e           state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic [CW-1:0]    credits_q, credits_d;
    logic [GW-1:0]    grant_q, grant_d;
    logic             vtx_valid_q, vtx_valid_d;
    logic [3:0][31:0] vtx_q, vtx_d;
    logic             col_valid_q, col_valid_d;
    logic [11:0]      col_q, col_d;
    logic [NUM_REQ-1:0] ready;
    logic [GW-1:0]    sel;
    logic             take;

    // ---------------------------------------------------------------- select
`ifdef TRI_ARB_ROUND_ROBIN_EN
    logic [GW-1:0] ptr_q, ptr_d;

    function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int off);
        int s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return GW'(s);
    endfunction

    // Scan downward so the requester closest to the pointer is assigned last.
    always_comb begin
        sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid_in[wrap_idx(ptr_q, i)]) sel = wrap_idx(ptr_q, i);
        end
    end

    // Pointer moves past the requester whose triangle just completed.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == COLOR && bus.req_valid_in[grant_q])
            ptr_d = (grant_q == GW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) ptr_q <= '0;
        else           ptr_q <= ptr_d;
    end
`else
    always_comb begin
        sel = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req_valid_in[i]) sel = GW'(i);
        end
    end
`endif

    // ------------------------------------------------------------------- FSM
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves one unassigned, which would infer a latch.
        state_d     = state_q;
        beat_d      = beat_q;
        grant_d     = grant_q;
        take        = 1'b0;
        ready       = '0;
        vtx_valid_d = 1'b0;
        vtx_d       = vtx_q;
        col_valid_d = 1'b0;
        col_d       = col_q;

        case (state_q)
            IDLE: begin
                // Grant only with a guaranteed FIFO slot; no beat accepted here.
                if (credits_q != '0 && |bus.req_valid_in) begin
                    take    = 1'b1;
                    grant_d = sel;
                    beat_d  = 2'd0;
                    state_d = VERTEX;
                end
            end
            VERTEX: begin
                ready[grant_q] = 1'b1;
                if (bus.req_valid_in[grant_q]) begin
                    vtx_valid_d = 1'b1;
                    vtx_d       = bus.req_vertex_in[grant_q];
                    if (beat_q == 2'd2) begin
                        beat_d  = 2'd0;
                        state_d = COLOR;
                    end else begin
                        beat_d  = beat_q + 1'b1;
                    end
                end
            end
            COLOR: begin
                ready[grant_q] = 1'b1;
                if (bus.req_valid_in[grant_q]) begin
                    col_valid_d = 1'b1;
                    col_d       = bus.req_color_in[grant_q];
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Credits: grant and pop in the same cycle cancel; pop saturates at full.
    always_comb begin
        credits_d = credits_q;
        if (take && !bus.pop_in)
            credits_d = credits_q - 1'b1;
        else if (!take && bus.pop_in && credits_q != CREDITS_FULL)
            credits_d = credits_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= IDLE;
            beat_q      <= 2'd0;
            credits_q   <= CREDITS_FULL;
            grant_q     <= '0;
            vtx_valid_q <= 1'b0;
            vtx_q       <= '0;
            col_valid_q <= 1'b0;
            col_q       <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            credits_q   <= credits_d;
            grant_q     <= grant_d;
            vtx_valid_q <= vtx_valid_d;
            vtx_q       <= vtx_d;
            col_valid_q <= col_valid_d;
            col_q       <= col_d;
        end
    end

    assign bus.req_ready_out    = ready;
    assign bus.vertex_valid_out = vtx_valid_q;
    assign bus.vertex_out       = vtx_q;
    assign bus.color_valid_out  = col_valid_q;
    assign bus.color_out        = col_q;
    assign bus.grant_out        = grant_q;
    assign bus.credits_out      = credits_q;
endmodule

// File: tb/tb_triangle_arbiter.sv
// -----------------------------------------------------------------------------
// tb_triangle_arbiter
//   Self-checking bench for triangle_arbiter. Producers are modelled as lists
//   of whole triangles; the output side is reassembled into triangles and
//   matched against the list of the requester named by grant_out. Arbitration
//   order is predicted from the selection rule over pending triangles.
//   Honours TRI_ARB_ROUND_ROBIN_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_triangle_arbiter;
    localparam int NUM_REQ = 2;
    localparam int CREDITS = 4;
    localparam int MAX_TRI = 8;
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(CREDITS + 1);

    typedef struct packed {
        logic [2:0][3:0][31:0] vtx;
        logic [11:0]           col;
    } tri_t;

    logic clk = 1'b0;
    logic rst_n;

    triangle_arbiter_if #(.NUM_REQ(NUM_REQ), .CREDITS(CREDITS)) bus ();

    triangle_arbiter #(.NUM_REQ(NUM_REQ), .CREDITS(CREDITS)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // producer model
    tri_t src [NUM_REQ][MAX_TRI];
    int   n_tri     [NUM_REQ];
    int   sent      [NUM_REQ];
    int   beat      [NUM_REQ];
    int   done      [NUM_REQ];
    int   stall_at  [NUM_REQ];
    int   stall_len [NUM_REQ];
    int   stall_cnt [NUM_REQ];
    int   gap_pct   [NUM_REQ];
    bit   auto_pop;
    int   occ;

    // output reassembly
    int   mon_beats;
    int   mon_grant;
    tri_t mon_tri;
    int   obs_g[$];
    int   vpulse_cnt;
    int   cpulse_cnt;

    // per-cycle snapshot taken at the falling edge
    logic [NUM_REQ-1:0] s_ready;
    logic [CW-1:0]      s_credits;
    logic [GW-1:0]      s_grant;

    int n_vec = 0;
    int n_err = 0;

    function automatic bit all_done();
        for (int r = 0; r < NUM_REQ; r++) if (done[r] != n_tri[r]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic gen_tri(input int r, input int i);
        for (int b = 0; b < 3; b++)
            for (int c = 0; c < 4; c++) src[r][i].vtx[b][c] = $urandom;
        src[r][i].col = 12'($urandom);
    endtask

    task automatic present();
        for (int r = 0; r < NUM_REQ; r++) begin
            bus.req_vertex_in[r] = {$urandom, $urandom, $urandom, $urandom};
            bus.req_color_in[r]  = 12'($urandom);
            bus.req_valid_in[r]  = 1'b0;
            if (sent[r] < n_tri[r]) begin
                if (stall_cnt[r] > 0) begin
                    stall_cnt[r]--;
                end else if ($urandom_range(99) >= gap_pct[r]) begin
                    bus.req_valid_in[r] = 1'b1;
                    if (beat[r] < 3) bus.req_vertex_in[r] = src[r][sent[r]].vtx[beat[r]];
                    else             bus.req_color_in[r]  = src[r][sent[r]].col;
                end
            end
        end
    endtask

    task automatic sample_and_monitor();
        int g;
        s_ready   = bus.req_ready_out;
        s_credits = bus.credits_out;
        s_grant   = bus.grant_out;
        n_vec += 2;
        if (s_ready !== '0 && s_ready !== (NUM_REQ'(1) << s_grant)) begin
            n_err++;
            $display("FAIL ready_vs_grant: ready=%b grant=%0d", s_ready, s_grant);
        end
        if (s_credits > CW'(CREDITS)) begin
            n_err++;
            $display("FAIL credits_range: got %0d, max %0d", s_credits, CREDITS);
        end
        if (bus.vertex_valid_out) begin
            vpulse_cnt++;
            if (mon_beats == 0) mon_grant = int'(bus.grant_out);
            n_vec++;
            if (int'(bus.grant_out) != mon_grant || mon_beats >= 3) begin
                n_err++;
                $display("FAIL vertex_beat: grant=%0d beats=%0d, need grant=%0d beats<3",
                         bus.grant_out, mon_beats, mon_grant);
            end
            if (mon_beats < 3) mon_tri.vtx[mon_beats] = bus.vertex_out;
            mon_beats++;
        end
        if (bus.color_valid_out) begin
            cpulse_cnt++;
            mon_tri.col = bus.color_out;
            g = (mon_beats == 0) ? int'(bus.grant_out) : mon_grant;
            n_vec += 2;
            if (mon_beats != 3 || int'(bus.grant_out) != g) begin
                n_err++;
                $display("FAIL color_beat: vertex beats=%0d grant=%0d, need 3 beats grant=%0d",
                         mon_beats, bus.grant_out, g);
            end
            if (done[g] >= n_tri[g]) begin
                n_err++;
                $display("FAIL unexpected_triangle: requester %0d had none pending", g);
            end else begin
                if (mon_tri !== src[g][done[g]]) begin
                    n_err++;
                    $display("FAIL triangle_data: req %0d got %h want %h", g, mon_tri, src[g][done[g]]);
                end
                done[g]++;
            end
            obs_g.push_back(g);
            occ++;
            mon_beats = 0;
        end
    endtask

    task automatic step(input bit pop_req);
        logic [NUM_REQ-1:0] hs;
        present();
        bus.pop_in = pop_req || (auto_pop && occ > 0 && $urandom_range(2) == 0);
        @(negedge clk);
        sample_and_monitor();
        hs = bus.req_valid_in & bus.req_ready_out;
        if (bus.pop_in && occ > 0) occ--;
        @(posedge clk);
        #1;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (hs[r]) begin
                beat[r]++;
                if (beat[r] == 4) begin
                    beat[r] = 0;
                    sent[r]++;
                end else if (beat[r] == stall_at[r]) begin
                    stall_cnt[r] = stall_len[r];
                end
            end
        end
    endtask

    task automatic run_until(input int budget, input string name);
        int c = 0;
        while (!all_done() && c < budget) begin
            step(1'b0);
            c++;
        end
        n_vec++;
        if (!all_done()) begin
            n_err++;
            $display("FAIL %s_timeout: not all triangles seen within %0d cycles", name, budget);
        end
    endtask

    task automatic do_reset();
        rst_n            = 1'b0;
        bus.req_valid_in = '0;
        bus.req_vertex_in = '0;
        bus.req_color_in = '0;
        bus.pop_in       = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) begin
            n_tri[r] = 0; sent[r] = 0; beat[r] = 0; done[r] = 0;
            stall_at[r] = -1; stall_len[r] = 0; stall_cnt[r] = 0; gap_pct[r] = 0;
        end
        auto_pop = 1'b0; occ = 0; mon_beats = 0; mon_grant = 0;
        vpulse_cnt = 0; cpulse_cnt = 0;
        obs_g.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        n_vec += 7;
        if (bus.req_ready_out !== '0) begin n_err++; $display("FAIL reset_ready: got %b want 0", bus.req_ready_out); end
        if (bus.vertex_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_vvalid: got %b want 0", bus.vertex_valid_out); end
        if (bus.vertex_out !== '0) begin n_err++; $display("FAIL reset_vertex: got %h want 0", bus.vertex_out); end
        if (bus.color_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_cvalid: got %b want 0", bus.color_valid_out); end
        if (bus.color_out !== '0) begin n_err++; $display("FAIL reset_color: got %h want 0", bus.color_out); end
        if (bus.grant_out !== '0) begin n_err++; $display("FAIL reset_grant: got %0d want 0", bus.grant_out); end
        if (bus.credits_out !== CW'(CREDITS)) begin n_err++; $display("FAIL reset_credits: got %0d want %0d", bus.credits_out, CREDITS); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_triangle();
        do_reset();
        n_tri[0] = 1;
        for (int b = 0; b < 3; b++)
            src[0][0].vtx[b] = {32'h43200000, 32'h42200000, 32'h3F000000, 32'hAAAAAAAA};
        src[0][0].col = 12'hF0F;
        run_until(50, "single");
        repeat (3) step(1'b0);
        n_vec += 5;
        if (vpulse_cnt != 3) begin n_err++; $display("FAIL single_vpulses: got %0d want 3", vpulse_cnt); end
        if (cpulse_cnt != 1) begin n_err++; $display("FAIL single_cpulses: got %0d want 1", cpulse_cnt); end
        if (s_credits !== CW'(3)) begin n_err++; $display("FAIL single_credits: got %0d want 3", s_credits); end
        if (bus.vertex_out !== src[0][0].vtx[2]) begin n_err++; $display("FAIL single_vertex_hold: got %h want %h", bus.vertex_out, src[0][0].vtx[2]); end
        if (bus.color_out !== 12'hF0F) begin n_err++; $display("FAIL single_color_hold: got %h want f0f", bus.color_out); end
    endtask

    task automatic test_contention();
        int rem [NUM_REQ];
        int last;
        int pick;
        int exp_g[$];
        do_reset();
        auto_pop = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
            n_tri[r] = 4;
            rem[r]   = 4;
            for (int i = 0; i < 4; i++) gen_tri(r, i);
        end
        // Predict the winner sequence when every requester with work left is valid.
        last = NUM_REQ - 1;
        for (int k = 0; k < 4 * NUM_REQ; k++) begin
            pick = -1;
`ifdef TRI_ARB_ROUND_ROBIN_EN
            for (int o = NUM_REQ; o >= 1; o--)
                if (rem[(last + o) % NUM_REQ] > 0) pick = (last + o) % NUM_REQ;
`else
            for (int r = NUM_REQ - 1; r >= 0; r--) if (rem[r] > 0) pick = r;
`endif
            exp_g.push_back(pick);
            rem[pick]--;
            last = pick;
        end
        run_until(600, "contention");
        n_vec++;
        if (obs_g.size() != exp_g.size()) begin
            n_err++;
            $display("FAIL contention_count: got %0d triangles want %0d", obs_g.size(), exp_g.size());
        end else begin
            for (int k = 0; k < exp_g.size(); k++) begin
                n_vec++;
                if (obs_g[k] != exp_g[k]) begin
                    n_err++;
                    $display("FAIL contention_order[%0d]: got grant %0d want %0d", k, obs_g[k], exp_g[k]);
                end
            end
        end
    endtask

    task automatic test_credit_exhaustion();
        int c = 0;
        do_reset();
        n_tri[0] = 5;
        for (int i = 0; i < 5; i++) gen_tri(0, i);
        while (done[0] < 4 && c < 200) begin step(1'b0); c++; end
        n_vec++;
        if (done[0] != 4) begin n_err++; $display("FAIL exhaust_fill: got %0d triangles want 4", done[0]); end
        for (int k = 0; k < 8; k++) begin
            step(1'b0);
            n_vec++;
            if (s_ready !== '0) begin n_err++; $display("FAIL exhaust_hold[%0d]: ready=%b want 0", k, s_ready); end
        end
        n_vec += 2;
        if (s_credits !== '0) begin n_err++; $display("FAIL exhaust_credits: got %0d want 0", s_credits); end
        if (sent[0] != 4) begin n_err++; $display("FAIL exhaust_fifth: accepted %0d triangles want 4", sent[0]); end
        step(1'b1);
        step(1'b0);
        n_vec += 2;
        if (s_credits !== CW'(1)) begin n_err++; $display("FAIL pop_credit: got %0d want 1", s_credits); end
        if (s_ready !== '0) begin n_err++; $display("FAIL pop_decide_ready: got %b want 0", s_ready); end
        step(1'b0);
        n_vec += 2;
        if (s_ready !== NUM_REQ'(1)) begin n_err++; $display("FAIL pop_grant_ready: got %b want 01", s_ready); end
        if (s_credits !== '0) begin n_err++; $display("FAIL pop_regrant_credits: got %0d want 0", s_credits); end
        run_until(100, "exhaust");
    endtask

    task automatic test_stall_and_overflow();
        int stalled = 0;
        int c = 0;
        bit stalling;
        do_reset();
        n_tri[0] = 1; n_tri[1] = 1;
        gen_tri(0, 0); gen_tri(1, 0);
        stall_at[0] = 1; stall_len[0] = 10;
        while (!all_done() && c < 200) begin
            stalling = (stall_cnt[0] > 0);
            step(1'b0);
            c++;
            if (stalling) begin
                stalled++;
                n_vec++;
                if (s_grant !== '0 || s_ready !== NUM_REQ'(1)) begin
                    n_err++;
                    $display("FAIL stall_hold: grant=%0d ready=%b want grant 0 ready 01", s_grant, s_ready);
                end
            end
        end
        n_vec += 3;
        if (stalled != 10) begin n_err++; $display("FAIL stall_len: stalled %0d cycles want 10", stalled); end
        if (!all_done()) begin n_err++; $display("FAIL stall_timeout: triangles not completed"); end
        if (obs_g.size() != 2 || obs_g[0] != 0) begin
            n_err++;
            $display("FAIL stall_order: got %0d triangles, first from %0d, want 2 with first 0",
                     obs_g.size(), (obs_g.size() > 0) ? obs_g[0] : -1);
        end
        do_reset();
        step(1'b1);
        step(1'b0);
        n_vec++;
        if (s_credits !== CW'(CREDITS)) begin n_err++; $display("FAIL pop_saturate: got %0d want %0d", s_credits, CREDITS); end
    endtask

    task automatic test_reset_mid_vertex();
        int c = 0;
        do_reset();
        n_tri[0] = 1;
        gen_tri(0, 0);
        while (beat[0] < 1 && c < 50) begin step(1'b0); c++; end
        n_vec++;
        if (beat[0] != 1) begin n_err++; $display("FAIL midreset_setup: beats accepted %0d want 1", beat[0]); end
        #2;
        rst_n = 1'b0;
        #1;
        n_vec += 4;
        if (bus.req_ready_out !== '0) begin n_err++; $display("FAIL midreset_ready: got %b want 0", bus.req_ready_out); end
        if (bus.credits_out !== CW'(CREDITS)) begin n_err++; $display("FAIL midreset_credits: got %0d want %0d", bus.credits_out, CREDITS); end
        if (bus.vertex_valid_out !== 1'b0) begin n_err++; $display("FAIL midreset_vvalid: got %b want 0", bus.vertex_valid_out); end
        if (bus.grant_out !== '0) begin n_err++; $display("FAIL midreset_grant: got %0d want 0", bus.grant_out); end
        @(negedge clk);
        @(negedge clk);
        n_vec += 2;
        if (bus.req_ready_out !== '0) begin n_err++; $display("FAIL midreset_hold_ready: got %b want 0", bus.req_ready_out); end
        if (bus.credits_out !== CW'(CREDITS)) begin n_err++; $display("FAIL midreset_hold_credits: got %0d want %0d", bus.credits_out, CREDITS); end
        do_reset();
    endtask

    task automatic test_random();
        int c = 0;
        do_reset();
        auto_pop = 1'b1;
        for (int r = 0; r < NUM_REQ; r++) begin
            n_tri[r] = 6;
            gap_pct[r] = 25;
            for (int i = 0; i < 6; i++) gen_tri(r, i);
        end
        run_until(3000, "random");
        while (occ > 0 && c < 200) begin step(1'b0); c++; end
        n_vec += 2;
        if (obs_g.size() != 6 * NUM_REQ) begin n_err++; $display("FAIL random_count: got %0d want %0d", obs_g.size(), 6 * NUM_REQ); end
        if (bus.credits_out !== CW'(CREDITS)) begin n_err++; $display("FAIL random_credits: got %0d want %0d", bus.credits_out, CREDITS); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_triangle();
        test_contention();
        test_credit_exhaustion();
        test_stall_and_overflow();
        test_reset_mid_vertex();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
